// File: rtl/sat_subtractor16.sv
// sat_subtractor16: multi-cycle signed x - y, carry chain split into two 8-bit halves.
// Define SAT_SUBTRACTOR_SAT_EN to clamp on overflow; otherwise the wrapped difference is returned.
module sat_subtractor16 #(
   parameter int BIT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] x,
   input  logic [BIT_WIDTH-1:0] y,
   output logic [BIT_WIDTH-1:0] result,
   output logic                 ovf,
   output logic                 out_valid,
   input  logic                 out_ready
);
   typedef enum logic [2:0] {IDLE, LO, HI, SAT, DONE} state_t;
   state_t               r_state;
   logic [BIT_WIDTH-1:0] r_x, r_y, r_result;
   logic [7:0]           r_lo, r_hi;
   logic                 r_c8, r_ov, r_ovf, r_out_valid, r_in_ready;
   logic [8:0]           w_lo_sum;
   logic [7:0]           w_hi;
   logic                 w_ov;
   logic [BIT_WIDTH-1:0] w_res;
   always_comb begin
      w_lo_sum = {1'b0, r_x[7:0]} + {1'b0, ~r_y[7:0]} + 9'd1;
      w_hi     = r_x[15:8] + ~r_y[15:8] + {7'd0, r_c8};
      // only operands of differing sign can overflow; the carry out of the top half is irrelevant
      w_ov     = (r_x[15] != r_y[15]) && (w_hi[7] != r_x[15]);
`ifdef SAT_SUBTRACTOR_SAT_EN
      w_res    = r_ov ? (r_x[15] ? 16'h8000 : 16'h7FFF) : {r_hi, r_lo};
`else
      w_res    = {r_hi, r_lo};
`endif
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_lo        <= '0;
         r_hi        <= '0;
         r_c8        <= 1'b0;
         r_ov        <= 1'b0;
         r_result    <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_x        <= x;
               r_y        <= y;
               r_in_ready <= 1'b0;
               r_state    <= LO;
            end
            LO: begin
               r_lo    <= w_lo_sum[7:0];
               r_c8    <= w_lo_sum[8];
               r_state <= HI;
            end
            HI: begin
               r_hi    <= w_hi;
               r_ov    <= w_ov;
               r_state <= SAT;
            end
            SAT: begin
               r_result    <= w_res;
               r_ovf       <= r_ov;
               r_out_valid <= 1'b1;
               r_state     <= DONE;
            end
            DONE: if (out_ready) begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end
   assign in_ready  = r_in_ready;
   assign result    = r_result;
   assign ovf       = r_ovf;
   assign out_valid = r_out_valid;
endmodule

// File: tb/tb_sat_subtractor16.sv
// tb_sat_subtractor16: vector table, random ops against an integer model, backpressure and reset-mid-op sequences.
module tb_sat_subtractor16;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] x = '0;
   logic [15:0] y = '0;
   logic [15:0] result;
   logic        ovf;
   logic        out_valid;
   logic        out_ready = 1'b0;
   int          checks = 0;
   int          errors = 0;

   sat_subtractor16 dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .result(result), .ovf(ovf),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        o;
   } vec_t;

`ifdef SAT_SUBTRACTOR_SAT_EN
   localparam logic [15:0] POS_OV = 16'h7FFF;
   localparam logic [15:0] NEG_OV = 16'h8000;
`else
   localparam logic [15:0] POS_OV = 16'h8000;
   localparam logic [15:0] NEG_OV = 16'h7FFF;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic o);
      int d;
      d = int'($signed(a)) - int'($signed(b));
      o = (d > 32767) || (d < -32768);
      r = d[15:0];
`ifdef SAT_SUBTRACTOR_SAT_EN
      if (o) r = (d > 0) ? 16'h7FFF : 16'h8000;
`endif
   endfunction

   // drives one op, checks latency and outputs, leaves out_valid held (not consumed)
   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input string nm,
                           input logic [15:0] er, input logic eo);
      int n;
      @(negedge clk);
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; x = a; y = b;
      @(posedge clk); #1;
      in_valid = 1'b0; x = 16'($urandom); y = 16'($urandom);
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_latency"}, 32'(n), 32'd3);
      chk({nm, "_result"}, 32'(result), 32'(er));
      chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
   endtask

   task automatic consume(input string nm);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, "_drop_valid"}, 32'(out_valid), 32'd0);
      chk({nm, "_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      vec_t        tbl [8];
      logic [15:0] a, b, er, hold_r;
      logic        eo, hold_o;
      tbl[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0};
      tbl[1] = '{16'h0100, 16'h0001, 16'h00FF, 1'b0};
      tbl[2] = '{16'h7FFF, 16'hFFFF, POS_OV, 1'b1};
      tbl[3] = '{16'h8000, 16'h0001, NEG_OV, 1'b1};
      tbl[4] = '{16'h0000, 16'h8000, POS_OV, 1'b1};
      tbl[5] = '{16'h8000, 16'h8000, 16'h0000, 1'b0};
      tbl[6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 1'b0};
      tbl[7] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         start_op(tbl[i].a, tbl[i].b, $sformatf("vec%0d", i), tbl[i].res, tbl[i].o);
         consume($sformatf("vec%0d", i));
      end

      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         if (i % 4 == 0) a = {a[15], {15{~a[15]}}} ^ {1'b0, 15'($urandom_range(0, 3))};
         model(a, b, er, eo);
         start_op(a, b, $sformatf("rnd%0d", i), er, eo);
         consume($sformatf("rnd%0d", i));
      end

      // backpressure: outputs frozen, in_valid pulses ignored
      start_op(16'h1234, 16'h0234, "bp", 16'h1000, 1'b0);
      hold_r = result;
      hold_o = ovf;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = i[0];
         x = 16'h0001; y = 16'h0001;
         @(posedge clk); #1;
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_result", 32'(result), 32'(hold_r));
         chk("bp_ovf", 32'(ovf), 32'(hold_o));
      end
      @(negedge clk);
      in_valid = 1'b0;
      consume("bp");
      repeat (5) @(posedge clk);
      #1;
      chk("bp_no_ghost", 32'(out_valid), 32'd0);

      // leave an overflowed result in the registers, then reset while in HI
      start_op(16'h7FFF, 16'hFFFF, "pre_rst", POS_OV, 1'b1);
      consume("pre_rst");
      @(negedge clk);
      in_valid = 1'b1; x = 16'h4000; y = 16'hC000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_result", 32'(result), 32'd0);
      chk("mid_rst_ovf", 32'(ovf), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      start_op(16'h0003, 16'h0005, "post_rst", 16'hFFFE, 1'b0);
      consume("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
